// File: rtl/ysyx_23060072_dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package ysyx_23060072_dmem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060072_dmem_responder_sram_1rw.sv
// Single-port DEPTH_WORDS x 32 array: per-byte write enable, registered read.
module ysyx_23060072_sram_1rw
  import ysyx_23060072_dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Read data only updates on an enabled access, so it holds between accesses.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/ysyx_23060072_dmem_responder.sv
// LSU-facing data-memory responder: one request at a time, fixed latency,
// response held until consumed.
module ysyx_23060072_dmem_responder
  import ysyx_23060072_dmem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [33:0] LIMIT    = 34'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic        rsp_load_q;
  logic        busy_q;

  logic        accept;
  logic        enter_resp;
  logic        a_we;
  logic        a_in_range;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] a_off;
  logic [3:0]  a_wstrb;
  logic [31:0] sram_rdata;

  // With LATENCY=1 the array is accessed on the handshake edge itself, so the
  // access port takes the live request in IDLE and the latched copy otherwise.
  always_comb begin
    accept     = (state_q == S_IDLE) && req_valid && req_ready_q;
    enter_resp = !rst && ((accept && (LATENCY == 1)) ||
                          ((state_q == S_WAIT) && (cnt_q == 4'd1)));
    if (state_q == S_IDLE) begin
      a_we    = req_we;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_wstrb = req_wstrb;
    end else begin
      a_we    = we_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_wstrb = wstrb_q;
    end
    a_off      = a_addr - BASE_ADDR;
    a_in_range = {2'b00, a_off} < LIMIT;
  end

  ysyx_23060072_sram_1rw #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk_i  (clk),
    .en_i   (enter_resp),
    .be_i   ((a_we && a_in_range) ? a_wstrb : 4'b0000),
    .addr_i (a_off[AW+1:2]),
    .wdata_i(a_wdata),
    .rdata_o(sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !a_in_range;
        rsp_load_q  <= !a_we && a_in_range;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  // The array's read register is frozen while in RESP, so gating it is stable.
  assign rsp_rdata = rsp_load_q ? sram_rdata : '0;

endmodule
